// File: rtl/hamming_tx_ctrl_pkg.sv
// rtl/hamming_tx_ctrl_pkg.sv - shared constants, FSM encoding and codeword layout helpers
//
// Purpose : widths and frame length for the 32->38 Hamming serial transmitter,
//           the controller state type, and constant functions that describe
//           where data and parity bits sit inside the codeword.
// Ports   : none (package).
package hamming_tx_ctrl_pkg;

    localparam int DATA_W    = 32;
    localparam int CODE_W    = 38;
    localparam int PAR_W     = 6;
    localparam int FRAME_LEN = CODE_W;
    localparam int BITCNT_W  = 6;
    localparam int FCNT_W    = 16;

    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_t;

    // Parity lives at 0-based positions 0,1,3,7,15,31, i.e. where pos+1 is a power of two.
    function automatic logic is_parity_pos(input int pos);
        return ((pos + 1) & pos) == 0;
    endfunction

    // Index of the payload bit placed at a data position: number of data slots below it.
    function automatic int data_index(input int pos);
        int n;
        n = 0;
        for (int j = 0; j < pos; j++) begin
            if (!is_parity_pos(j)) begin
                n++;
            end
        end
        return n;
    endfunction

    // Positions checked by the parity bit at parity position ppos: every
    // 1-based position sharing the power-of-two bit of ppos+1.
    function automatic logic [CODE_W-1:0] cover_mask(input int ppos);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int j = 0; j < CODE_W; j++) begin
            if (((j + 1) & (ppos + 1)) != 0) begin
                m[j] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming_code.sv
// rtl/hamming_code.sv - combinational 32->38 Hamming encoder
//
// Purpose : spreads the payload over the non-parity codeword positions and
//           fills each parity position with the even parity of the positions
//           it covers.
// Ports   : data_i [31:0] payload word
//           code_o [37:0] encoded codeword, bit 0 = 1-based position 1
module hamming_code
    import hamming_tx_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [CODE_W-1:0] code_o
);

    // Codeword with payload placed and all parity slots still zero, so a
    // parity bit never folds itself into its own XOR.
    logic [CODE_W-1:0] data_only;

    for (genvar pos = 0; pos < CODE_W; pos++) begin : g_spread
        if (is_parity_pos(pos)) begin : g_par
            assign data_only[pos] = 1'b0;
        end else begin : g_dat
            assign data_only[pos] = data_i[data_index(pos)];
        end
    end

    for (genvar pos = 0; pos < CODE_W; pos++) begin : g_code
        if (is_parity_pos(pos)) begin : g_par
            assign code_o[pos] = ^(data_only & cover_mask(pos));
        end else begin : g_dat
            assign code_o[pos] = data_only[pos];
        end
    end

endmodule

// File: rtl/hamming_tx_ctrl.sv
// rtl/hamming_tx_ctrl.sv - one-word buffered Hamming-coded serial frame transmitter
//
// Purpose : accepts 32-bit words through a valid/ready handshake into a
//           one-entry hold register, encodes them to 38-bit Hamming codewords
//           and shifts each codeword out serially, with a programmable idle gap
//           between frames and a completed-frame counter.
// Ports   : clk, rst_n          clock, asynchronous active-low reset
//           inValid/inReady     producer handshake, inData [31:0] payload
//           txEn                line enable; low freezes the shifter
//           serOut/serValid     serial bit and its qualifier
//           frameStart          first bit of a frame on serOut
//           busy                hold register full or FSM not idle
//           frameCnt [15:0]     completed frames, wrapping
module hamming_tx_ctrl
    import hamming_tx_ctrl_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] inData,
    input  logic              txEn,
    output logic              serOut,
    output logic              serValid,
    output logic              frameStart,
    output logic              busy,
    output logic [FCNT_W-1:0] frameCnt
);

    tx_state_t           state_q, state_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic [CODE_W-1:0]   shreg_q, shreg_d;
    logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [15:0]         gap_cnt_q, gap_cnt_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic [CODE_W-1:0]   code;
    logic                accept;
    logic                load_clear;
    logic                in_shift;

    hamming_code u_enc (
        .data_i (hold_q),
        .code_o (code)
    );

    assign accept = inValid && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        load_clear  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shreg_d    = code;
                bit_cnt_d  = '0;
                load_clear = 1'b1;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (txEn) begin
                    // The bit on serOut is always the end of the register
                    // facing the line, so advance away from that end.
                    if (MSB_FIRST) begin
                        shreg_d = {shreg_q[CODE_W-2:0], 1'b0};
                    end else begin
                        shreg_d = {1'b0, shreg_q[CODE_W-1:1]};
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                        bit_cnt_d   = '0;
                        gap_cnt_d   = '0;
                        state_d     = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 16'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new word arriving on the edge that LOAD frees the register wins,
        // so the slot is refilled rather than dropped.
        if (accept) begin
            hold_d      = inData;
            hold_full_d = 1'b1;
        end else if (load_clear) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign in_shift   = (state_q == ST_SHIFT);
    assign inReady    = !hold_full_q;
    assign serOut     = in_shift && (MSB_FIRST ? shreg_q[CODE_W-1] : shreg_q[0]);
    assign serValid   = in_shift && txEn;
    assign frameStart = serValid && (bit_cnt_q == '0);
    assign busy       = hold_full_q || (state_q != ST_IDLE);
    assign frameCnt   = frame_cnt_q;

endmodule

// File: tb/tb_hamming_tx_ctrl.sv
// tb/tb_hamming_tx_ctrl.sv - self-checking bench for hamming_tx_ctrl
module tb_hamming_tx_ctrl;

    localparam int GAP_CYCLES = 2;
    localparam bit MSB_FIRST  = 1'b0;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [31:0] inData;
    logic        txEn;
    logic        serOut;
    logic        serValid;
    logic        frameStart;
    logic        busy;
    logic [15:0] frameCnt;

    hamming_tx_ctrl #(
        .GAP_CYCLES (GAP_CYCLES),
        .MSB_FIRST  (MSB_FIRST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inValid    (inValid),
        .inReady    (inReady),
        .inData     (inData),
        .txEn       (txEn),
        .serOut     (serOut),
        .serValid   (serValid),
        .frameStart (frameStart),
        .busy       (busy),
        .frameCnt   (frameCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [37:0] exp_q[$];
    logic [15:0] exp_cnt = 16'd0;
    int          cyc = 0;
    int          last_end = -1;
    int          gap_meas = -1;
    bit          rand_en = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder: payload fills the non-power-of-two 1-based slots;
    // the parity word is the XOR of the 1-based indices of every set data bit.
    function automatic logic [37:0] golden(input logic [31:0] d);
        logic [37:0] cw;
        int          k;
        int          syn;
        int          n;
        cw  = '0;
        k   = 0;
        syn = 0;
        for (int p = 0; p < 38; p++) begin
            n = p + 1;
            if ((n & (n - 1)) != 0) begin
                cw[p] = d[k];
                if (d[k]) syn = syn ^ n;
                k++;
            end
        end
        for (int b = 0; b < 6; b++) begin
            cw[(1 << b) - 1] = syn[b];
        end
        return cw;
    endfunction

    // Line monitor: rebuilds frames from serOut and scores them against exp_q.
    initial begin
        int          nbits;
        bit          cnt_pending;
        logic [37:0] rx;
        logic [37:0] want;
        nbits = 0;
        cnt_pending = 1'b0;
        rx = '0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!rst_n) begin
                nbits = 0;
                cnt_pending = 1'b0;
                last_end = -1;
            end else begin
                if (cnt_pending) begin
                    check_eq("frame_cnt", frameCnt, exp_cnt);
                    cnt_pending = 1'b0;
                end
                if (serValid) begin
                    check_eq("frame_start", frameStart, nbits == 0);
                    if (nbits == 0 && last_end >= 0) gap_meas = cyc - last_end - 1;
                    rx[MSB_FIRST ? 37 - nbits : nbits] = serOut;
                    nbits++;
                    if (nbits == 38) begin
                        check_eq("frame_expected", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            want = exp_q.pop_front();
                            check_eq("frame_data", rx, want);
                        end
                        exp_cnt = exp_cnt + 16'd1;
                        cnt_pending = 1'b1;
                        nbits = 0;
                        last_end = cyc;
                    end
                end else begin
                    check_eq("start_wo_valid", frameStart, 0);
                end
                if (!busy) check_eq("idle_outs", {serOut, serValid, frameStart}, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rand_en) txEn = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic push(input logic [31:0] d, input logic [37:0] cw, output logic acc_in_shift);
        int n;
        n = 0;
        acc_in_shift = 1'b0;
        inValid = 1'b1;
        inData  = d;
        while (!inReady && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_accept", inReady, 1);
        if (inReady) begin
            acc_in_shift = serValid;
            exp_q.push_back(cw);
        end
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_done", n < 5000, 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (!frameStart && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("start_seen", frameStart, 1);
    endtask

    initial begin
        logic        acc;
        logic        held;
        logic [31:0] a;
        logic [31:0] b;

        rst_n   = 1'b0;
        inValid = 1'b0;
        inData  = '0;
        txEn    = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_outs", {serOut, serValid, frameStart, busy}, 0);
        check_eq("rst_ready", inReady, 1);
        check_eq("rst_fcnt", frameCnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word 1 -> codeword 7, two-edge latency to first bit
        push(32'h0000_0001, 38'h7, acc);
        #1;
        check_eq("lat_busy", busy, 1);
        check_eq("lat_ready_low", inReady, 0);
        check_eq("lat_idle_valid", serValid, 0);
        @(negedge clk);
        #1;
        check_eq("lat_load_valid", serValid, 0);
        @(negedge clk);
        #1;
        check_eq("lat_first_valid", serValid, 1);
        check_eq("lat_first_start", frameStart, 1);
        check_eq("lat_first_bit", serOut, 1);
        @(negedge clk);
        drain();
        #1;
        check_eq("single_fcnt", frameCnt, 16'd1);
        @(negedge clk);

        // txEn low for 5 cycles at bit 10
        push(32'h0, golden(32'h0), acc);
        wait_start();
        repeat (10) @(negedge clk);
        txEn = 1'b0;
        held = serOut;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("pause_valid", serValid, 0);
            check_eq("pause_hold", serOut, held);
            @(negedge clk);
        end
        txEn = 1'b1;
        drain();
        #1;
        check_eq("pause_fcnt", frameCnt, 16'd2);
        @(negedge clk);

        // Back-to-back words: B accepted during A's shift, fixed inter-frame gap
        a = $urandom;
        b = $urandom;
        push(a, golden(a), acc);
        push(b, golden(b), acc);
        check_eq("b2b_acc_in_shift", acc, 1);
        #1;
        check_eq("b2b_ready_low", inReady, 0);
        @(negedge clk);
        drain();
        check_eq("b2b_gap", gap_meas, GAP_CYCLES + 2);
        #1;
        check_eq("b2b_fcnt", frameCnt, 16'd4);
        @(negedge clk);

        // Second word offered while the first is in LOAD
        a = $urandom;
        b = $urandom;
        push(a, golden(a), acc);
        push(b, golden(b), acc);
        drain();

        // Reset in the middle of a frame with a second word held
        a = $urandom;
        b = $urandom;
        push(a, golden(a), acc);
        wait_start();
        @(negedge clk);
        push(b, golden(b), acc);
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        exp_cnt = 16'd0;
        #1;
        check_eq("mid_rst_outs", {serOut, serValid, frameStart, busy}, 0);
        check_eq("mid_rst_fcnt", frameCnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("mid_rst_ready", inReady, 1);
        repeat (60) @(negedge clk);
        #1;
        check_eq("mid_rst_no_frame", frameCnt, 0);
        check_eq("mid_rst_idle", busy, 0);
        @(negedge clk);

        // Random words with random line stalls
        rand_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            push(a, golden(a), acc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        rand_en = 1'b0;
        txEn = 1'b1;
        #1;
        check_eq("rand_fcnt", frameCnt, 16'd40);
        @(negedge clk);

        // Counter wrap: preload near the top, then three more frames
        force dut.frame_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.frame_cnt_q;
        exp_cnt = 16'hFFFE;
        @(negedge clk);
        rand_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            push(a, golden(a), acc);
        end
        drain();
        rand_en = 1'b0;
        txEn = 1'b1;
        #1;
        check_eq("wrap_fcnt", frameCnt, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
